// File: rtl/apple_iie_timing_if.sv
// Bus bundle between the timing generator and its consumers (MMU/IOU/video).
// The master drives the mode/enable inputs; the slave is the timing generator.
interface apple_iie_timing_if #(
  parameter int HCOUNT_W = 7
);
  logic                entmg;
  logic                ramen_n;
  logic                eighty_vid_n;
  logic                gr;
  logic                vid7;
  logic                clk_7M;
  logic                clk_3_58M;
  logic                clk_q3;
  logic                clk_phi_0;
  logic                pras_n;
  logic                pcas_n;
  logic                ldps_n;
  logic                vid7m;
  logic                h0;
  logic [HCOUNT_W-1:0] hcount;

  modport master (
    output entmg, ramen_n, eighty_vid_n, gr, vid7,
    input  clk_7M, clk_3_58M, clk_q3, clk_phi_0, pras_n, pcas_n,
           ldps_n, vid7m, h0, hcount
  );

  modport slave (
    input  entmg, ramen_n, eighty_vid_n, gr, vid7,
    output clk_7M, clk_3_58M, clk_q3, clk_phi_0, pras_n, pcas_n,
           ldps_n, vid7m, h0, hcount
  );
endinterface

// File: rtl/apple_iie_timing_gen.sv
// Apple IIe timing generator: divides the 14M master clock into 7M, colour
// reference, Q3 and PHI0, tracks the CPU cycle within a scan line and issues
// the interleaved video/CPU DRAM strobes plus shifter load / shift enables.
// Optional feature macro: APPLE_IIE_PAL_LONG_CYCLE_EN stretches the last
// cycle of each line by LONG_EXTRA ticks (PHI0 half only).
// t_q/hc_q hold the tick that the next enabled edge will present, so every
// output is a register loaded from that position.
module apple_iie_timing_gen #(
  parameter int TICKS_PER_CYCLE = 14,
  parameter int CYCLES_PER_LINE = 65,
  parameter int LONG_EXTRA      = 2,
  parameter int RAS_FALL        = 1,
  parameter int CAS_FALL        = 3,
  parameter int Q3_HIGH         = 4,
  parameter int LDPS_TICK       = 12,
  parameter int HCOUNT_W        = 7
) (
  input  logic               clk_14M,
  input  logic               reset_n,
  apple_iie_timing_if.slave  bus
);
  localparam int H = TICKS_PER_CYCLE / 2;
`ifdef APPLE_IIE_PAL_LONG_CYCLE_EN
  localparam int EXTRA = LONG_EXTRA;
`else
  localparam int EXTRA = LONG_EXTRA * 0;
`endif
  localparam int TW = $clog2(TICKS_PER_CYCLE + EXTRA);

  localparam logic [TW-1:0] T_H         = TW'(H);
  localparam logic [TW-1:0] T_END       = TW'(TICKS_PER_CYCLE - 1);
  localparam logic [TW-1:0] T_END_LONG  = TW'(TICKS_PER_CYCLE + EXTRA - 1);
  localparam logic [TW-1:0] P1_LAST     = TW'(H - 1);
  localparam logic [TW-1:0] P0_LAST     = TW'(TICKS_PER_CYCLE - H - 1);
  localparam logic [TW-1:0] P0_LAST_LNG = TW'(TICKS_PER_CYCLE + EXTRA - H - 1);
  localparam logic [TW-1:0] T_RAS       = TW'(RAS_FALL);
  localparam logic [TW-1:0] T_CAS       = TW'(CAS_FALL);
  localparam logic [TW-1:0] T_Q3        = TW'(Q3_HIGH);
  localparam logic [TW-1:0] T_LD        = TW'(LDPS_TICK);
  localparam logic [TW-1:0] T_LD80      = TW'(LDPS_TICK - H);
  localparam logic [HCOUNT_W-1:0] HC_LAST = HCOUNT_W'(CYCLES_PER_LINE - 1);

  logic [TW-1:0]       t_q, t_d;
  logic [HCOUNT_W-1:0] hc_q, hc_d, hcnt_q;
  logic [1:0]          div_q;
  logic                d_q, d_d, ramen_q, ramen_d;
  logic                q3_q, q3_d, phi0_q, ras_q, ras_d, cas_q, cas_d;
  logic                ldps_q, ldps_d, v7m_q, v7m_d;

  logic                phi0, long_cyc, ramen_s, ld, strobe_win_ras, strobe_win_cas;
  logic [TW-1:0]       p, p_last, t_end;

  // Decode the upcoming tick into phase position and next-state values.
  always_comb begin
    long_cyc       = (hc_q == HC_LAST);
    t_end          = long_cyc ? T_END_LONG : T_END;
    phi0           = (t_q >= T_H);
    p              = phi0 ? (t_q - T_H) : t_q;
    p_last         = phi0 ? (long_cyc ? P0_LAST_LNG : P0_LAST) : P1_LAST;
    // ramen_n is live only on the first PHI0 tick; CAS never falls there anyway.
    ramen_s        = (t_q == T_H) ? bus.ramen_n : ramen_q;
    ramen_d        = ramen_s;
    ld             = (t_q == T_LD) || (!bus.eighty_vid_n && (t_q == T_LD80));
    strobe_win_ras = (p >= T_RAS) && (p < p_last);
    strobe_win_cas = (p >= T_CAS) && (p < p_last);
    q3_d           = (p < T_Q3);
    ras_d          = !strobe_win_ras;
    cas_d          = !(strobe_win_cas && !(phi0 && ramen_s));
    ldps_d         = !ld;
    v7m_d          = !bus.eighty_vid_n || (t_q[0] == d_q);
    d_d            = ld ? (bus.gr & bus.vid7 & bus.eighty_vid_n) : d_q;
    t_d            = (t_q == t_end) ? '0 : t_q + TW'(1);
    hc_d           = hc_q;
    if (t_q == t_end) hc_d = (hc_q == HC_LAST) ? '0 : hc_q + HCOUNT_W'(1);
  end

  // Register state and outputs; entmg low freezes everything, reset wins.
  always_ff @(posedge clk_14M) begin
    if (!reset_n) begin
      t_q     <= '0;
      hc_q    <= '0;
      hcnt_q  <= '0;
      div_q   <= '0;
      d_q     <= 1'b0;
      ramen_q <= 1'b0;
      q3_q    <= 1'b0;
      phi0_q  <= 1'b0;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      ldps_q  <= 1'b1;
      v7m_q   <= 1'b0;
    end else if (bus.entmg) begin
      t_q     <= t_d;
      hc_q    <= hc_d;
      hcnt_q  <= hc_q;
      div_q   <= div_q + 2'd1;
      d_q     <= d_d;
      ramen_q <= ramen_d;
      q3_q    <= q3_d;
      phi0_q  <= phi0;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      ldps_q  <= ldps_d;
      v7m_q   <= v7m_d;
    end
  end

  assign bus.clk_7M    = div_q[0];
  assign bus.clk_3_58M = div_q[1];
  assign bus.clk_q3    = q3_q;
  assign bus.clk_phi_0 = phi0_q;
  assign bus.pras_n    = ras_q;
  assign bus.pcas_n    = cas_q;
  assign bus.ldps_n    = ldps_q;
  assign bus.vid7m     = v7m_q;
  assign bus.h0        = hcnt_q[0];
  assign bus.hcount    = hcnt_q;
endmodule

// File: tb/tb_apple_iie_timing_gen.sv
// Self-checking bench for apple_iie_timing_gen: a line-position reference
// model (absolute tick index -> cycle/tick) predicts every output per tick.
module tb_apple_iie_timing_gen;
  localparam int TPC = 14, CPL = 65, H = 7, RAS = 1, CAS = 3, Q3 = 4, LDPS = 12;
`ifdef APPLE_IIE_PAL_LONG_CYCLE_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LINE = CPL * TPC + EXTRA;
  localparam logic [15:0] RESET_V = 16'b0000_1110_0000_0000;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  apple_iie_timing_if #(.HCOUNT_W(7)) bus();

  apple_iie_timing_gen dut (.clk_14M(clk), .reset_n(reset_n), .bus(bus));

  logic [15:0] dut_v;
  assign dut_v = {bus.clk_7M, bus.clk_3_58M, bus.clk_q3, bus.clk_phi_0, bus.pras_n,
                  bus.pcas_n, bus.ldps_n, bus.vid7m, bus.h0, bus.hcount};

  int checks = 0, errors = 0;
  int n = 0, m_div = 0, cur_t = 0, cur_hc = 0;
  bit m_d = 0, m_ram = 0;
  logic [15:0] exp_v = RESET_V;

  // Absolute tick index within the line -> (cycle, tick).
  function automatic void pos(input int k, output int t, output int hc);
    int q;
    q = k % LINE;
    if (q < (CPL - 1) * TPC) begin hc = q / TPC; t = q % TPC; end
    else begin hc = CPL - 1; t = q - (CPL - 1) * TPC; end
  endfunction

  // One clock edge; the model consumes the inputs present at that edge.
  task automatic step();
    int t, hc, len, p, pl;
    bit ph, ld;
    @(posedge clk);
    if (!reset_n) begin
      n = 0; m_div = 0; m_d = 0; m_ram = 0; exp_v = RESET_V; cur_t = 0; cur_hc = 0;
    end else if (bus.entmg) begin
      pos(n, t, hc);
      len = (hc == CPL - 1) ? TPC + EXTRA : TPC;
      ph  = (t >= H);
      p   = ph ? t - H : t;
      pl  = ph ? len - H : H;
      if (t == H) m_ram = bus.ramen_n;
      ld  = (t == LDPS) || (!bus.eighty_vid_n && t == LDPS - H);
      m_div = (m_div + 1) % 4;
      exp_v = {m_div[0], m_div[1], p < Q3, ph, !(p >= RAS && p < pl - 1),
               !(p >= CAS && p < pl - 1 && !(ph && m_ram)), !ld,
               (!bus.eighty_vid_n) || ((t % 2) == int'(m_d)), hc[0], 7'(hc)};
      if (ld) m_d = bus.gr & bus.vid7 & bus.eighty_vid_n;
      cur_t = t; cur_hc = hc;
      n++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; step(); reset_n = 1'b1;
  endtask

  task automatic align();
    int t, hc;
    for (int i = 0; i < 40; i++) begin
      pos(n, t, hc);
      if (t == 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    bus.entmg = 1'b0; reset_n = 1'b0; step();
    checks++;
    if (dut_v !== RESET_V) begin errors++; $display("FAIL reset_vec got %h want %h", dut_v, RESET_V); end
    bus.entmg = 1'b1; reset_n = 1'b1; step();
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL first_tick got %h want %h", dut_v, exp_v); end
    checks++;
    if ({bus.clk_phi_0, bus.clk_q3, bus.pras_n, bus.hcount} !== {3'b011, 7'd0}) begin
      errors++; $display("FAIL tick0_fields got %b want 0110000000",
                         {bus.clk_phi_0, bus.clk_q3, bus.pras_n, bus.hcount});
    end
  endtask

  task automatic test_phases();
    int phi_hi = 0, ras_lo = 0, cas_lo = 0, q3_hi = 0;
    bus.ramen_n = 1'b0; bus.eighty_vid_n = 1'b1; bus.gr = 1'b0;
    do_reset();
    for (int i = 0; i < 2 * TPC; i++) begin
      step();
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL phases t%0d got %h want %h", cur_t, dut_v, exp_v); end
      if (i < TPC) begin
        phi_hi += int'(bus.clk_phi_0); ras_lo += int'(!bus.pras_n);
        cas_lo += int'(!bus.pcas_n);   q3_hi  += int'(bus.clk_q3);
      end
    end
    checks++;
    if ({phi_hi, ras_lo, cas_lo, q3_hi} !== {32'd7, 32'd10, 32'd6, 32'd8}) begin
      errors++; $display("FAIL phase_counts got phi%0d ras%0d cas%0d q3%0d want phi7 ras10 cas6 q38",
                         phi_hi, ras_lo, cas_lo, q3_hi);
    end
  endtask

  task automatic test_ramen();
    int ras_lo = 0, cas_lo = 0, cas_lo0 = 0;
    for (int i = 0; i < 200; i++) begin
      bus.ramen_n = 1'($urandom);
      step();
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL ramen_rand t%0d got %h want %h", cur_t, dut_v, exp_v); end
    end
    bus.ramen_n = 1'b1;
    align();
    for (int i = 0; i < TPC; i++) begin
      step();
      ras_lo += int'(!bus.pras_n); cas_lo += int'(!bus.pcas_n);
      if (cur_t >= H) cas_lo0 += int'(!bus.pcas_n);
    end
    checks++;
    if ({ras_lo, cas_lo, cas_lo0} !== {32'd10, 32'd3, 32'd0}) begin
      errors++; $display("FAIL ramen_suppress got ras%0d cas%0d cas_phi0 %0d want ras10 cas3 cas_phi0 0",
                         ras_lo, cas_lo, cas_lo0);
    end
    bus.ramen_n = 1'b0;
  endtask

  task automatic test_line();
    int last_wrap = -1, period = -1, long_ticks = 0, long_phi = 0, prev_hc = 0;
    do_reset();
    for (int i = 0; i < 2 * LINE + 5; i++) begin
      bus.ramen_n = 1'($urandom);
      step();
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL line h%0d t%0d got %h want %h", cur_hc, cur_t, dut_v, exp_v); end
      if (i < LINE && bus.hcount == 7'(CPL - 1)) begin
        long_ticks++; long_phi += int'(bus.clk_phi_0);
      end
      if (prev_hc == CPL - 1 && bus.hcount == 7'd0) begin
        if (last_wrap >= 0) period = i - last_wrap;
        last_wrap = i;
      end
      prev_hc = int'(bus.hcount);
    end
    checks++;
    if (period !== LINE) begin errors++; $display("FAIL line_period got %0d want %0d", period, LINE); end
    checks++;
    if ({long_ticks, long_phi} !== {TPC + EXTRA, H + EXTRA}) begin
      errors++; $display("FAIL last_cycle got len%0d phi%0d want len%0d phi%0d",
                         long_ticks, long_phi, TPC + EXTRA, H + EXTRA);
    end
  endtask

  task automatic test_40col();
    bit want [4];
    int ld_cnt;
    logic [1:0] v01;
    bus.eighty_vid_n = 1'b1; bus.gr = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      want[k] = (k % 2) == 0;
      ld_cnt = 0; v01 = 2'b00;
      for (int j = 0; j < TPC; j++) begin
        bus.vid7 = (j == LDPS) ? want[k] : 1'($urandom);
        step();
        checks++;
        if (dut_v !== exp_v) begin errors++; $display("FAIL col40 t%0d got %h want %h", cur_t, dut_v, exp_v); end
        ld_cnt += int'(!bus.ldps_n);
        if (j < 2) v01[j] = bus.vid7m;
      end
      checks++;
      if (ld_cnt !== 1) begin errors++; $display("FAIL col40_ldcnt got %0d want 1", ld_cnt); end
      if (k > 0) begin
        checks++;
        if (v01 !== (want[k-1] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL col40_delay got %b want %b", v01, want[k-1] ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_80col();
    int ld_cnt, v_cnt;
    bus.eighty_vid_n = 1'b0; bus.gr = 1'b1;
    align();
    for (int k = 0; k < 2; k++) begin
      ld_cnt = 0; v_cnt = 0;
      for (int j = 0; j < TPC; j++) begin
        bus.vid7 = 1'b1;
        step();
        checks++;
        if (dut_v !== exp_v) begin errors++; $display("FAIL col80 t%0d got %h want %h", cur_t, dut_v, exp_v); end
        if (!bus.ldps_n && (j == 5 || j == LDPS)) ld_cnt++;
        else if (!bus.ldps_n) ld_cnt += 100;
        v_cnt += int'(bus.vid7m);
      end
      checks++;
      if ({ld_cnt, v_cnt} !== {32'd2, 32'(TPC)}) begin
        errors++; $display("FAIL col80_cycle got ld%0d v%0d want ld2 v%0d", ld_cnt, v_cnt, TPC);
      end
    end
    bus.eighty_vid_n = 1'b1;
    step();
    checks++;
    if (bus.vid7m !== 1'b1) begin errors++; $display("FAIL col80_dflag got %b want 1", bus.vid7m); end
  endtask

  task automatic test_hold();
    logic [15:0] held;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    held = dut_v;
    bus.entmg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ramen_n = 1'($urandom); bus.vid7 = 1'($urandom); bus.gr = 1'($urandom);
      step();
      checks++;
      if (dut_v !== held) begin errors++; $display("FAIL hold got %h want %h", dut_v, held); end
    end
    bus.entmg = 1'b1; bus.gr = 1'b0;
    step();
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL resume got %h want %h", dut_v, exp_v); end
    checks++;
    if ({bus.clk_phi_0, bus.pras_n, bus.clk_q3} !== 3'b101) begin
      errors++; $display("FAIL resume_t10 got %b want 101", {bus.clk_phi_0, bus.pras_n, bus.clk_q3});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) step();
    reset_n = 1'b0; bus.entmg = 1'b0;
    step();
    checks++;
    if (dut_v !== RESET_V) begin errors++; $display("FAIL reset_mid got %h want %h", dut_v, RESET_V); end
    reset_n = 1'b1; bus.entmg = 1'b1;
    step();
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL reset_restart got %h want %h", dut_v, exp_v); end
  endtask

  initial begin
    bus.entmg = 1'b1; bus.ramen_n = 1'b0; bus.eighty_vid_n = 1'b1;
    bus.gr = 1'b0; bus.vid7 = 1'b0;
    test_reset();
    test_phases();
    test_ramen();
    test_line();
    test_40col();
    test_80col();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
